// File: rtl/exp_arbiter_if.sv
// Requester and shared-exp-unit signal bundle for exp_arbiter.
// slave = arbiter side, master = requesters plus exp unit side.
interface exp_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_x;
  logic [4*NREQ-1:0]    req_ibits;
  logic [NREQ-1:0]      req_ready;
  logic                 eu_valid;
  logic [31:0]          eu_x;
  logic [3:0]           eu_ibits;
  logic                 eu_out_valid;
  logic [31:0]          eu_exp_x;
  logic [NREQ-1:0]      resp_valid;
  logic [31:0]          resp_data;

  modport slave (
    input  req_valid, req_x, req_ibits, eu_out_valid, eu_exp_x,
    output req_ready, eu_valid, eu_x, eu_ibits, resp_valid, resp_data
  );

  modport master (
    output req_valid, req_x, req_ibits, eu_out_valid, eu_exp_x,
    input  req_ready, eu_valid, eu_x, eu_ibits, resp_valid, resp_data
  );
endinterface

// File: rtl/exp_arbiter.sv
// Round-robin arbiter sharing one fixed-latency exp unit among NREQ requesters.
// Define EXP_ARB_STATS_EN to add grant_cnt/stall_cnt saturating statistics outputs.
module exp_arbiter #(
  parameter int NREQ   = 4,
  parameter int EU_LAT = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  exp_arbiter_if.slave       bus,
  output logic               busy,
  output logic               tag_err
`ifdef EXP_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0] grant_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int          IDXW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U = NREQ;
  typedef logic [IDXW-1:0] idx_t;

  idx_t              rr_ptr_q, rr_ptr_d;
  logic              eu_valid_q, eu_valid_d;
  logic [31:0]       eu_x_q, eu_x_d;
  logic [3:0]        eu_ibits_q, eu_ibits_d;
  logic [EU_LAT-1:0] tag_vld_q, tag_vld_d;
  idx_t              tag_idx_q [EU_LAT];
  idx_t              tag_idx_d [EU_LAT];
  logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              tag_err_q, tag_err_d;

  logic              grant_found;
  idx_t              grant_idx;
  idx_t              cand_idx;
  int unsigned       cand;
  logic [NREQ-1:0]   req_ready;
  logic              xfer;
  logic              end_vld;
  idx_t              end_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      cand     = (32'(rr_ptr_q) + k) % NREQ_U;
      cand_idx = idx_t'(cand);
      if (!grant_found && bus.req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign req_ready     = (rst && en && grant_found) ? (NREQ'(1) << grant_idx) : '0;
  assign bus.req_ready = req_ready;
  assign xfer          = |(bus.req_valid & req_ready);

  // Tag stage 0 loads on the same edge as eu_valid, so the last stage lines up
  // with eu_out_valid from the exp unit.
  assign end_vld = tag_vld_q[EU_LAT-1];
  assign end_idx = tag_idx_q[EU_LAT-1];

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    eu_valid_d   = xfer;
    eu_x_d       = eu_x_q;
    eu_ibits_d   = eu_ibits_q;
    if (xfer) begin
      rr_ptr_d   = (grant_idx == idx_t'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      eu_x_d     = bus.req_x[32*grant_idx +: 32];
      eu_ibits_d = bus.req_ibits[4*grant_idx +: 4];
    end

    tag_vld_d    = '0;
    tag_vld_d[0] = xfer;
    tag_idx_d[0] = grant_idx;
    for (int unsigned k = 1; k < EU_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end

    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (bus.eu_out_valid && end_vld) begin
      resp_valid_d = NREQ'(1) << end_idx;
      resp_data_d  = bus.eu_exp_x;
    end
    tag_err_d = tag_err_q | (bus.eu_out_valid ^ end_vld);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q     <= '0;
      eu_valid_q   <= 1'b0;
      eu_x_q       <= '0;
      eu_ibits_q   <= '0;
      tag_vld_q    <= '0;
      tag_idx_q    <= '{default: '0};
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      tag_err_q    <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      eu_valid_q   <= eu_valid_d;
      eu_x_q       <= eu_x_d;
      eu_ibits_q   <= eu_ibits_d;
      tag_vld_q    <= tag_vld_d;
      tag_idx_q    <= tag_idx_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      tag_err_q    <= tag_err_d;
    end
  end

  assign bus.eu_valid   = eu_valid_q;
  assign bus.eu_x       = eu_x_q;
  assign bus.eu_ibits   = eu_ibits_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign tag_err        = tag_err_q;
  assign busy           = eu_valid_q | (|tag_vld_q) | (|resp_valid_q);

`ifdef EXP_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NREQ];
  logic [15:0] grant_cnt_d [NREQ];
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (xfer && grant_idx == idx_t'(i) && grant_cnt_q[i] != '1)
        grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
    end
    stall_cnt_d = stall_cnt_q;
    if ((|bus.req_valid) && !xfer && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_cnt_q <= '{default: '0};
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NREQ_U; i++)
      grant_cnt[16*i +: 16] = grant_cnt_q[i];
  end
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exp_arbiter.sv
// Randomized scoreboard bench for exp_arbiter with a stand-in exp unit of fixed latency.
module tb_exp_arbiter;
  localparam int NREQ   = 4;
  localparam int EU_LAT = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic busy, tag_err;

  exp_arbiter_if #(.NREQ(NREQ)) bus ();

`ifdef EXP_ARB_STATS_EN
  logic [16*NREQ-1:0] grant_cnt;
  logic [15:0]        stall_cnt;
`endif

  exp_arbiter #(.NREQ(NREQ), .EU_LAT(EU_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .bus     (bus),
    .busy    (busy),
    .tag_err (tag_err)
`ifdef EXP_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Arbitrary but input-dependent stand-in for the exp function; exp(0) in Q0.31 saturates.
  function automatic logic [31:0] eu_func(logic [31:0] x, logic [3:0] ib);
    return 32'h7FFF_FFFF - (x ^ {ib, 28'h0});
  endfunction

  // Exp unit stand-in: result valid EU_LAT-1 cycles after the cycle eu_valid is high,
  // giving request-to-response latency of EU_LAT+1.
  bit          eu_force = 1'b0;
  bit          eu_pv [EU_LAT-1];
  logic [31:0] eu_pd [EU_LAT-1];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < EU_LAT-1; i++) begin
        eu_pv[i] <= 1'b0;
        eu_pd[i] <= '0;
      end
    end else begin
      eu_pv[0] <= bus.eu_valid;
      eu_pd[0] <= eu_func(bus.eu_x, bus.eu_ibits);
      for (int i = 1; i < EU_LAT-1; i++) begin
        eu_pv[i] <= eu_pv[i-1];
        eu_pd[i] <= eu_pd[i-1];
      end
    end
  end
  assign bus.eu_out_valid = eu_pv[EU_LAT-2] | eu_force;
  assign bus.eu_exp_x     = eu_pd[EU_LAT-2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every response strobe must match the oldest outstanding accept.
  always @(negedge clk) begin
    if (bus.resp_valid != '0) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL resp_unexpected: got resp_valid %b expected none (cycle %0d)", bus.resp_valid, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("resp_valid", 32'(bus.resp_valid), 32'(1) << mon_e.idx);
        check("resp_data", bus.resp_data, mon_e.data);
        check("resp_cycle", cyc, mon_e.due);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      checks++;
      fails++;
      $display("FAIL resp_missing: got no resp_valid expected requester %0d (cycle %0d)", sb[0].idx, cyc);
      void'(sb.pop_front());
    end
  end

  int m_ptr = 0;
  int m_gcnt [NREQ];
  int m_stall = 0;

  task automatic cycle(input logic [NREQ-1:0] v, input bit e, input bit r, input bit zero_ops);
    logic [NREQ-1:0] exp_rdy;
    int g;
    bus.req_valid = v;
    en  = e;
    rst = r;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[32*i +: 32]  = zero_ops ? 32'h0 : $urandom;
      bus.req_ibits[4*i +: 4] = zero_ops ? 4'h0 : 4'($urandom);
    end
    @(negedge clk);
    g = -1;
    if (r && e)
      for (int k = 0; k < NREQ && g < 0; k++)
        if (v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    if (g >= 0) begin
      sb.push_back('{due: cyc + EU_LAT + 1, idx: g,
                     data: eu_func(bus.req_x[32*g +: 32], bus.req_ibits[4*g +: 4])});
      m_ptr = (g + 1) % NREQ;
      m_gcnt[g]++;
    end else if (v != '0) begin
      m_stall++;
    end
    @(posedge clk);
    if (!r) begin
      sb.delete();
      m_ptr = 0;
      m_gcnt = '{default: 0};
      m_stall = 0;
    end
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 40) begin
      cycle('0, 1'b1, 1'b1, 1'b0);
      n++;
    end
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_ibits = '0;
    m_gcnt        = '{default: 0};

    repeat (3) cycle('0, 1'b0, 1'b0, 1'b0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tag_err", 32'(tag_err), 32'd0);
    check("rst_eu_valid", 32'(bus.eu_valid), 32'd0);
    check("rst_eu_x", bus.eu_x, 32'd0);
    check("rst_eu_ibits", 32'(bus.eu_ibits), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);

    // single request with x=0, ibits=0
    cycle(4'b0001, 1'b1, 1'b1, 1'b1);
    check("busy_inflight", 32'(busy), 32'd1);
    drain();
    check("resp_hold", bus.resp_data, 32'h7FFF_FFFF);

    // all requesting from rr_ptr=0
    cycle('0, 1'b0, 1'b0, 1'b0);
    repeat (8) cycle(4'b1111, 1'b1, 1'b1, 1'b0);
    drain();

    // en low blocks grants
    cycle('0, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(4'b0101, 1'b0, 1'b1, 1'b0);
    repeat (2) cycle(4'b0101, 1'b1, 1'b1, 1'b0);
    drain();

    // reset with three operations in flight
    repeat (3) cycle(4'b1111, 1'b1, 1'b1, 1'b0);
    cycle('0, 1'b1, 1'b0, 1'b0);
    check("busy_after_rst", 32'(busy), 32'd0);
    repeat (12) cycle('0, 1'b1, 1'b1, 1'b0);
    check("busy_idle", 32'(busy), 32'd0);
    cycle(4'b1111, 1'b1, 1'b1, 1'b0);
    drain();

    // result strobe with no tag in flight
    check("tag_err_clear", 32'(tag_err), 32'd0);
    eu_force = 1'b1;
    cycle('0, 1'b1, 1'b1, 1'b0);
    eu_force = 1'b0;
    check("tag_err_set", 32'(tag_err), 32'd1);
    repeat (5) cycle('0, 1'b1, 1'b1, 1'b0);
    check("tag_err_sticky", 32'(tag_err), 32'd1);
    cycle('0, 1'b1, 1'b0, 1'b0);
    check("tag_err_rst", 32'(tag_err), 32'd0);

    // randomized traffic with occasional en drops and resets
    for (int n = 0; n < 400; n++)
      cycle(NREQ'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) != 0), 1'b0);
    drain();
    check("tag_err_random", 32'(tag_err), 32'd0);
`ifdef EXP_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) check("grant_cnt_random", 32'(grant_cnt[16*i +: 16]), 32'(m_gcnt[i]));
    check("stall_cnt_random", 32'(stall_cnt), 32'(m_stall));

    cycle('0, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(4'b0010, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle(4'b0010, 1'b0, 1'b1, 1'b0);
    drain();
    check("grant_cnt1", 32'(grant_cnt[31:16]), 32'd5);
    check("stall_cnt", 32'(stall_cnt), 32'd3);
    check("grant_cnt0", 32'(grant_cnt[15:0]), 32'd0);
`endif
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end
endmodule
